// File: rtl/fx_pkg.sv
// rtl/fx_pkg.sv - shared constants and helpers for the fixed-point MAC lanes
// Purpose: rounding-mode encodings, accumulator width and saturation bounds.
package fx_pkg;

    localparam logic [1:0] RND_TRUNC     = 2'd0;
    localparam logic [1:0] RND_HALF_UP   = 2'd1;
    localparam logic [1:0] RND_HALF_EVEN = 2'd2;

    // Wide enough to sum KMAX full-width products without ever wrapping.
    function automatic int acc_width(input int width, input int kmax);
        return $clog2(kmax + 1) + 2 * width;
    endfunction

    function automatic longint sat_max(input int width);
        return (longint'(1) <<< (width - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

endpackage

// File: rtl/fx_round_sat.sv
// rtl/fx_round_sat.sv - per-lane rounding, rescale and saturation
// Purpose: turn a WA-bit Q-format window sum into a WIDTH-bit result.
// Ports:
//   sum_i   - signed accumulated window sum (2*FRACTION fractional bits)
//   rmode_i - rounding mode (truncate / half-up / half-even)
//   res_o   - rounded, saturated result (FRACTION fractional bits)
//   sat_o   - result was clipped to the representable range
module fx_round_sat
    import fx_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int FRACTION = 4,
    parameter int WA       = 21
) (
    input  logic signed [WA-1:0]    sum_i,
    input  logic        [1:0]       rmode_i,
    output logic        [WIDTH-1:0] res_o,
    output logic                    sat_o
);

    localparam logic        [FRACTION-1:0] HALF  = FRACTION'(1) << (FRACTION - 1);
    localparam logic signed [WA-1:0]       MAX_V = WA'(sat_max(WIDTH));
    localparam logic signed [WA-1:0]       MIN_V = WA'(sat_min(WIDTH));

    logic        [FRACTION-1:0] frac;
    logic                       inc;
    logic signed [WA-1:0]       shifted;
    logic signed [WA-1:0]       rounded;

    always_comb begin
        frac = sum_i[FRACTION-1:0];
        inc  = 1'b0;
        case (rmode_i)
            RND_HALF_UP:   inc = (frac >= HALF);
            // Ties go to the even neighbour: look at the lowest kept bit.
            RND_HALF_EVEN: inc = (frac > HALF) || ((frac == HALF) && sum_i[FRACTION]);
            default:       inc = 1'b0;
        endcase
        shifted = sum_i >>> FRACTION;
        // Increment before the range check so a round-up past the top saturates.
        rounded = shifted + $signed({{(WA-1){1'b0}}, inc});
        if (rounded > MAX_V) begin
            res_o = MAX_V[WIDTH-1:0];
            sat_o = 1'b1;
        end else if (rounded < MIN_V) begin
            res_o = MIN_V[WIDTH-1:0];
            sat_o = 1'b1;
        end else begin
            res_o = rounded[WIDTH-1:0];
            sat_o = 1'b0;
        end
    end

endmodule

// File: rtl/fx_mac_lanes.sv
// rtl/fx_mac_lanes.sv - multi-lane fixed-point multiply-accumulate engine
// Purpose: LANES signed products per beat, summed over k beats per window,
//          rounded, saturated and handed off on a valid/ready output.
// Ports:
//   clk, rstn        - clock, asynchronous active-low reset
//   k_i              - beats per window, latched on the first beat
//   rmode_i          - rounding mode, taken from the last beat of a window
//   s_valid/s_ready  - input beat handshake
//   win, din         - packed per-lane weights and data
//   m_valid/m_ready  - result handshake
//   acc_o, sat_o     - packed per-lane results and saturation flags
module fx_mac_lanes
    import fx_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int FRACTION = 4,
    parameter int LANES    = 4,
    parameter int KMAX     = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [$clog2(KMAX+1)-1:0]     k_i,
    input  logic [1:0]                    rmode_i,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [LANES*WIDTH-1:0]        win,
    input  logic [LANES*WIDTH-1:0]        din,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [LANES*WIDTH-1:0]        acc_o,
    output logic [LANES-1:0]              sat_o
);

    localparam int KW = $clog2(KMAX + 1);
    localparam int WA = acc_width(WIDTH, KMAX);
    localparam int PW = 2 * WIDTH;
    localparam logic [KW-1:0] KMAX_K = KW'(KMAX);

    logic [KW-1:0]             cnt_q, cnt_d;
    logic [KW-1:0]             keff_q, keff_d;
    logic                      p_valid_q, p_valid_d;
    logic                      p_last_q, p_last_d;
    logic [1:0]                rmode_p_q, rmode_p_d;
    logic signed [PW-1:0]      p_q [LANES];
    logic signed [PW-1:0]      p_d [LANES];
    logic signed [WA-1:0]      acc_q [LANES];
    logic signed [WA-1:0]      acc_d [LANES];
    logic                      m_valid_q, m_valid_d;
    logic [LANES*WIDTH-1:0]    acc_o_q, acc_o_d;
    logic [LANES-1:0]          sat_o_q, sat_o_d;

    logic signed [WA-1:0]      sum_w [LANES];
    logic [LANES*WIDTH-1:0]    res_w;
    logic [LANES-1:0]          sat_w;

    logic                      stall;
    logic                      accept;
    logic                      out_load;
    logic [KW-1:0]             k_new;
    logic [KW-1:0]             k_cur;

    for (genvar n = 0; n < LANES; n++) begin : g_lane
        assign sum_w[n] = acc_q[n] + $signed({{(WA-PW){p_q[n][PW-1]}}, p_q[n]});

        fx_round_sat #(
            .WIDTH    (WIDTH),
            .FRACTION (FRACTION),
            .WA       (WA)
        ) u_round_sat (
            .sum_i    (sum_w[n]),
            .rmode_i  (rmode_p_q),
            .res_o    (res_w[n*WIDTH +: WIDTH]),
            .sat_o    (sat_w[n])
        );
    end

    // A finished window waiting on a full output register freezes both stages.
    assign stall   = p_valid_q & p_last_q & m_valid_q & ~m_ready;
    assign s_ready = ~stall;
    assign m_valid = m_valid_q;
    assign acc_o   = acc_o_q;
    assign sat_o   = sat_o_q;

    always_comb begin
        accept   = s_valid & ~stall;
        out_load = p_valid_q & p_last_q & (~m_valid_q | m_ready);
        k_new    = (k_i == '0) ? KW'(1) : ((k_i > KMAX_K) ? KMAX_K : k_i);
        // The first beat of a window uses the freshly clamped k; later beats use the latch.
        k_cur    = (cnt_q == '0) ? k_new : keff_q;

        cnt_d     = cnt_q;
        keff_d    = keff_q;
        p_valid_d = p_valid_q;
        p_last_d  = p_last_q;
        rmode_p_d = rmode_p_q;
        m_valid_d = m_valid_q;
        acc_o_d   = acc_o_q;
        sat_o_d   = sat_o_q;
        for (int n = 0; n < LANES; n++) begin
            p_d[n]   = p_q[n];
            acc_d[n] = acc_q[n];
        end

        if (accept) begin
            keff_d    = k_cur;
            p_valid_d = 1'b1;
            p_last_d  = (cnt_q == k_cur - KW'(1));
            cnt_d     = p_last_d ? '0 : cnt_q + KW'(1);
            rmode_p_d = rmode_i;
            for (int n = 0; n < LANES; n++) begin
                p_d[n] = $signed(win[n*WIDTH +: WIDTH]) * $signed(din[n*WIDTH +: WIDTH]);
            end
        end else if (!stall) begin
            p_valid_d = 1'b0;
        end

        if (p_valid_q && !p_last_q) begin
            for (int n = 0; n < LANES; n++) begin
                acc_d[n] = sum_w[n];
            end
        end

        if (out_load) begin
            m_valid_d = 1'b1;
            acc_o_d   = res_w;
            sat_o_d   = sat_w;
            for (int n = 0; n < LANES; n++) begin
                acc_d[n] = '0;
            end
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q     <= '0;
            keff_q    <= '0;
            p_valid_q <= 1'b0;
            p_last_q  <= 1'b0;
            rmode_p_q <= RND_TRUNC;
            m_valid_q <= 1'b0;
            acc_o_q   <= '0;
            sat_o_q   <= '0;
            for (int n = 0; n < LANES; n++) begin
                p_q[n]   <= '0;
                acc_q[n] <= '0;
            end
        end else begin
            cnt_q     <= cnt_d;
            keff_q    <= keff_d;
            p_valid_q <= p_valid_d;
            p_last_q  <= p_last_d;
            rmode_p_q <= rmode_p_d;
            m_valid_q <= m_valid_d;
            acc_o_q   <= acc_o_d;
            sat_o_q   <= sat_o_d;
            for (int n = 0; n < LANES; n++) begin
                p_q[n]   <= p_d[n];
                acc_q[n] <= acc_d[n];
            end
        end
    end

endmodule

// File: doc/fx_mac_lanes.md
# fx_mac_lanes

Multi-lane fixed-point multiply-accumulate engine, the next generation of the single-lane MAC in the convolution datapath. It runs LANES independent signed Qm.FRACTION products per beat and accumulates a runtime-selectable number of beats (1..KMAX) per window. Each window result is rounded with a selectable mode, saturated to WIDTH bits, and presented on a valid/ready output with per-lane saturation flags. The block sits between the operand fetch unit and the activation/requantisation stage, and applies back-pressure through `s_ready`.

## Interface
- WIDTH, 8: operand and result width per lane (signed, two's complement).
- FRACTION, 4: fractional bits of operands and result. Must be ≥ 1 and < WIDTH.
- LANES, 4: number of parallel lanes.
- KMAX, 16: maximum accumulation length. Must be ≥ 1.
- clk  in  1  clock, rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- k_i  in  $clog2(KMAX+1)  beats per window. Sampled on the first beat of each window.
- rmode_i  in  2  rounding mode: 0 truncate (floor), 1 round-half-up, 2 round-half-even, 3 same as 0. Sampled on the last beat of each window.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid & s_ready.
- win  in  LANES*WIDTH  per-lane weights; lane n occupies bits [n*WIDTH +: WIDTH].
- din  in  LANES*WIDTH  per-lane data, same packing as win.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts the result.
- acc_o  out  LANES*WIDTH  per-lane rounded, saturated result, same packing as win.
- sat_o  out  LANES  per-lane flag: result was clipped.

## Operation
- Accumulator width: WA = $clog2(KMAX+1) + 2*WIDTH. Products are full 2*WIDTH, sign-extended to WA. There is no intermediate clipping.
- k latching: on the first accepted beat of a window, k_eff = max(1, min(k_i, KMAX)). k_i changes mid-window are ignored.
- Stage P (product register): each accepted beat loads p[n] = win[n]*din[n], p_valid=1, and p_last = (beat count == k_eff−1). The beat counter resets to 0 after the last beat.
- Stage A (accumulate/output):
  - When p_valid & ~p_last: acc[n] += p[n].
  - When p_valid & p_last and the output register is free (~m_valid | m_ready):
    - s = acc[n] + p[n];
    - r = round(s) >> FRACTION (arithmetic);
    - clip to [−2^(WIDTH−1), 2^(WIDTH−1)−1];
    - load acc_o and sat_o; set m_valid=1; clear acc[n] to 0.
- Rounding, with F = low FRACTION bits of s and H = 2^(FRACTION−1):
  - Mode 0: no increment.
  - Mode 1: round up when F ≥ H.
  - Mode 2: round up when F > H, or when F == H and bit FRACTION of s is 1.
  - The increment is applied before the range check, so a rounded value that overflows is saturated.
- Stall: stall = p_valid & p_last & m_valid & ~m_ready. During a stall, stage P holds and the accumulators hold.
- s_ready = ~stall. This is combinational from m_valid, m_ready and the P-stage flags, with no path from s_valid.
- m_valid clears on m_ready unless a new result loads in the same cycle. acc_o and sat_o hold while m_valid & ~m_ready.
- All lanes share control. Lanes never desynchronise.

## Timing
- Reset values: s_ready=1, m_valid=0, acc_o=0, sat_o=0. Internally p_valid=0, counter=0, acc=0.
- Reset mid-window discards the partial window. No result is emitted for it.
- Latency: last beat accepted at cycle t → m_valid=1 at t+2, when unstalled.
- Throughput:
  - One beat per cycle sustained with m_ready=1.
  - With k_eff=1, one result per cycle.
- Simultaneous events:
  - m_ready with a new last-beat result in the same cycle: the new result loads and m_valid stays 1.
  - Both results are seen by the consumer. None is dropped or duplicated.

## Structure
- Shared package `fx_pkg`:
  - rounding-mode constants RND_TRUNC=0, RND_HALF_UP=1, RND_HALF_EVEN=2;
  - function for WA;
  - saturation bound constants as functions of WIDTH.
- Sub-module `fx_round_sat` (combinational, per lane):
  - inputs: WA-bit sum and rmode;
  - outputs: WIDTH-bit result and sat flag.
  - Instantiated LANES times with a generate loop.
- The top module holds the counter, k_eff latch, P/A registers and handshake.

## Test plan
All scenarios use WIDTH=8, FRACTION=4, LANES=4, KMAX=16. Values are Q4.4, so 0x10 = 1.0.
1. k_i=3, all lanes win=din=0x10, three beats, m_ready=1 → one result per lane acc_o=0x30, sat_o=0, m_valid two cycles after beat 3.
2. Saturation, k_i=4:
   - lane0 win=din=0x7F → 0x7F, sat=1;
   - lane1 win=0x80, din=0x7F → 0x80, sat=1;
   - lanes 2–3 zero → 0x00, sat=0.
3. Rounding, k_i=1, lane inputs (0x01,0x08), (0x01,0x18), (0xFF,0x08):
   - rmode 0 → 0x00, 0x01, 0xFF;
   - rmode 1 → 0x01, 0x02, 0x00;
   - rmode 2 → 0x00, 0x02, 0x00.
4. Back-pressure, k_i=1, continuous s_valid, m_ready low for 5 cycles → s_ready drops after the second result reaches stage P. No beat is lost and results are in order once m_ready rises.
5. k_i=0 and k_i=20 → treated as 1 and 16 beats. Changing k_i mid-window does not alter the window length.
6. rstn asserted after 2 of 4 beats, then a fresh 4-beat window → only the fresh window's sum appears. Outputs are 0 during reset.
